imem_loadable: RTL and testbench

Parametrised successor to the fixed instruction ROM. Instruction memory for the MIPS8 core with a registered fetch port and a byte-serial load port, fed from the board UART/debug bridge. Programs are reloaded at run time without resynthesis. While a load is in progress the core is held and fetches return NOP.

---
 rtl/imem_loadable_if.sv | 41 ++++
 rtl/imem_loadable.sv | 161 ++++++++++++++++
 tb/tb_imem_loadable.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loadable_if.sv
// Fetch and byte-serial load bus for imem_loadable.
// master drives fetch/load requests; slave is the memory side.
interface imem_loadable_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  fetch_en;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data;
  logic                  data_valid;
  logic                  load_start;
  logic                  load_stop;
  logic                  load_valid;
  logic [7:0]            load_byte;
  logic                  load_ready;
  logic                  load_done;
  logic                  load_overflow;
  logic                  cpu_hold;
  logic [ADDR_WIDTH:0]   word_count;
  logic [7:0]            checksum;

  modport master (
    output fetch_en, address,
    output load_start, load_stop,
    output load_valid, load_byte,
    input  data, data_valid,
    input  load_ready, load_done,
    input  load_overflow, cpu_hold,
    input  word_count, checksum
  );

  modport slave (
    input  fetch_en, address,
    input  load_start, load_stop,
    input  load_valid, load_byte,
    output data, data_valid,
    output load_ready, load_done,
    output load_overflow, cpu_hold,
    output word_count, checksum
  );
endinterface

// File: rtl/imem_loadable.sv
// Loadable instruction memory: registered fetch port plus byte-serial
// program load (big-endian bytes, MSB first) with core hold while loading.
// Ports: clk, rst_n (async active-low), bus (imem_loadable_if.slave):
//   fetch_en/address -> data/data_valid, load_start/stop/valid/byte ->
//   load_ready/done/overflow, cpu_hold, word_count, checksum.
// Optional: define IMEM_CHECKSUM_EN for the mod-256 byte checksum;
// otherwise checksum is tied to 0.
module imem_loadable #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256
) (
  input logic             clk,
  input logic             rst_n,
  imem_loadable_if.slave  bus
);

  localparam int BPW = DATA_WIDTH / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW  = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] LAST    = CW'(BPW - 1);
  localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);

  typedef enum logic {RUN, LOAD} state_t;

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] asm_q;
  logic [CW-1:0]         bcnt_q;
  logic [PW-1:0]         ptr_q;
  logic                  ovf_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  dv_q;

  logic                  in_load;
  logic                  offer;
  logic                  full;
  logic                  acc;
  logic                  drop;
  logic                  last_b;
  logic                  wr;
  logic                  leave;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] rd;

  // load_start has priority over load_stop in either state
  always_comb begin
    state_d = state_q;
    if (bus.load_start)
      state_d = LOAD;
    else if (state_q == LOAD && bus.load_stop)
      state_d = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  assign in_load = (state_q == LOAD);
  assign full    = (ptr_q == DEPTH_W);
  // a restart cycle consumes no byte
  assign offer   = in_load && bus.load_valid
                && !ovf_q && !bus.load_start;
  assign acc     = offer && !full;
  assign drop    = offer && full;
  assign last_b  = (bcnt_q == LAST);
  assign wr      = acc && last_b;
  assign leave   = in_load && (state_d == RUN);
  assign word    = (asm_q << 8) | DATA_WIDTH'(bus.load_byte);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q  <= '0;
      bcnt_q <= '0;
      ptr_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= leave;
      if (bus.load_start) begin
        asm_q  <= '0;
        bcnt_q <= '0;
        ptr_q  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (acc) begin
          if (last_b) begin
            asm_q  <= '0;
            bcnt_q <= '0;
            ptr_q  <= ptr_q + PW'(1);
          end else begin
            asm_q  <= word;
            bcnt_q <= bcnt_q + CW'(1);
          end
        end
        if (drop)
          ovf_q <= 1'b1;
        // partial word is discarded on exit
        if (leave) begin
          asm_q  <= '0;
          bcnt_q <= '0;
        end
      end
    end
  end

  // array has no reset so programs survive rst_n
  always_ff @(posedge clk) begin
    if (wr)
      mem[ptr_q[IW-1:0]] <= word;
  end

  assign rd = ({1'b0, bus.address} < DEPTH_W)
            ? mem[bus.address[IW-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      dv_q   <= 1'b0;
    end else if (in_load) begin
      data_q <= '0;
      dv_q   <= 1'b0;
    end else if (bus.fetch_en) begin
      data_q <= rd;
      dv_q   <= 1'b1;
    end else begin
      dv_q   <= 1'b0;
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      csum_q <= '0;
    else if (bus.load_start)
      csum_q <= '0;
    else if (acc)
      csum_q <= csum_q + bus.load_byte;
  end

  assign bus.checksum = csum_q;
`else
  assign bus.checksum = '0;
`endif

  assign bus.data          = data_q;
  assign bus.data_valid    = dv_q;
  assign bus.load_ready    = in_load && !ovf_q;
  assign bus.load_done     = done_q;
  assign bus.load_overflow = ovf_q;
  assign bus.cpu_hold      = in_load;
  assign bus.word_count    = ptr_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench for imem_loadable: default instance plus a DEPTH=4
// instance for overflow; fetch results are checked by queue monitors.
module tb_imem_loadable;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  imem_loadable_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) i0 ();
  imem_loadable_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) i1 ();

  imem_loadable #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(256)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(i0)
  );

  imem_loadable #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(i1)
  );

  int ncmp = 0;
  int nmis = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] e0, e1;

  function automatic logic [7:0] cs(input logic [7:0] v);
`ifdef IMEM_CHECKSUM_EN
    return v;
`else
    return 8'h00;
`endif
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && i0.data_valid) begin
      ncmp++;
      if (q0.size() == 0) begin
        nmis++;
        $display("FAIL fetch0: got %h, expected no fetch", i0.data);
      end else begin
        e0 = q0.pop_front();
        if (i0.data !== e0) begin
          nmis++;
          $display("FAIL fetch0: got %h, expected %h", i0.data, e0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && i1.data_valid) begin
      ncmp++;
      if (q1.size() == 0) begin
        nmis++;
        $display("FAIL fetch1: got %h, expected no fetch", i1.data);
      end else begin
        e1 = q1.pop_front();
        if (i1.data !== e1) begin
          nmis++;
          $display("FAIL fetch1: got %h, expected %h", i1.data, e1);
        end
      end
    end
  end

  task automatic send0(input logic [7:0] b);
    i0.load_valid = 1'b1;
    i0.load_byte  = b;
    @(negedge clk);
    i0.load_valid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] b);
    i1.load_valid = 1'b1;
    i1.load_byte  = b;
    @(negedge clk);
    i1.load_valid = 1'b0;
  endtask

  task automatic fetch0(input logic [7:0] a, input logic [15:0] e);
    i0.fetch_en = 1'b1;
    i0.address  = a;
    q0.push_back(e);
    @(negedge clk);
    i0.fetch_en = 1'b0;
  endtask

  task automatic fetch1(input logic [7:0] a, input logic [15:0] e);
    i1.fetch_en = 1'b1;
    i1.address  = a;
    q1.push_back(e);
    @(negedge clk);
    i1.fetch_en = 1'b0;
  endtask

  task automatic pulse0(input logic st, input logic sp);
    i0.load_start = st;
    i0.load_stop  = sp;
    @(negedge clk);
    i0.load_start = 1'b0;
    i0.load_stop  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  logic [7:0] prog [20] = '{
    8'h48, 8'h00, 8'h4A, 8'h0C, 8'h4C, 8'h06, 8'h4E, 8'h00,
    8'h64, 8'h00, 8'h68, 8'h48, 8'h0E, 8'h80, 8'h5C, 8'h02,
    8'h88, 8'h20, 8'h00, 8'h00
  };

  initial begin
    i0.fetch_en = 0; i0.address = 0; i0.load_start = 0;
    i0.load_stop = 0; i0.load_valid = 0; i0.load_byte = 0;
    i1.fetch_en = 0; i1.address = 0; i1.load_start = 0;
    i1.load_stop = 0; i1.load_valid = 0; i1.load_byte = 0;

    repeat (3) @(negedge clk);
    chk("rst data", {16'h0, i0.data}, 0);
    chk("rst dv", {31'h0, i0.data_valid}, 0);
    chk("rst ready", {31'h0, i0.load_ready}, 0);
    chk("rst done", {31'h0, i0.load_done}, 0);
    chk("rst ovf", {31'h0, i0.load_overflow}, 0);
    chk("rst hold", {31'h0, i0.cpu_hold}, 0);
    chk("rst wc", {23'h0, i0.word_count}, 0);
    chk("rst cs", {24'h0, i0.checksum}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // DEPTH=4 overflow
    i1.load_start = 1'b1;
    @(negedge clk);
    i1.load_start = 1'b0;
    chk("d4 ready", {31'h0, i1.load_ready}, 1);
    for (int k = 1; k <= 8; k++) send1(8'(k));
    chk("d4 wc full", {23'h0, i1.word_count}, 4);
    chk("d4 ovf pre", {31'h0, i1.load_overflow}, 0);
    chk("d4 ready pre", {31'h0, i1.load_ready}, 1);
    i1.load_valid = 1'b1;
    i1.load_byte  = 8'h09;
    @(negedge clk);
    chk("d4 ovf set", {31'h0, i1.load_overflow}, 1);
    chk("d4 ready drop", {31'h0, i1.load_ready}, 0);
    i1.load_byte = 8'h0A;
    @(negedge clk);
    i1.load_valid = 1'b0;
    chk("d4 ovf sticky", {31'h0, i1.load_overflow}, 1);
    chk("d4 wc hold", {23'h0, i1.word_count}, 4);
    chk("d4 cs", {24'h0, i1.checksum}, {24'h0, cs(8'h24)});
    i1.load_stop = 1'b1;
    @(negedge clk);
    i1.load_stop = 1'b0;
    chk("d4 done", {31'h0, i1.load_done}, 1);
    chk("d4 ovf after stop", {31'h0, i1.load_overflow}, 1);
    fetch1(8'h03, 16'h0708);
    fetch1(8'h0A, 16'h0000);
    i1.load_start = 1'b1;
    @(negedge clk);
    i1.load_start = 1'b0;
    chk("d4 ovf clr", {31'h0, i1.load_overflow}, 0);
    chk("d4 wc clr", {23'h0, i1.word_count}, 0);
    chk("d4 ready again", {31'h0, i1.load_ready}, 1);
    i1.load_stop = 1'b1;
    @(negedge clk);
    i1.load_stop = 1'b0;

    // full program load
    pulse0(1'b1, 1'b0);
    chk("ld hold", {31'h0, i0.cpu_hold}, 1);
    chk("ld ready", {31'h0, i0.load_ready}, 1);
    i0.fetch_en = 1'b1;
    i0.address  = 8'h00;
    @(negedge clk);
    i0.fetch_en = 1'b0;
    chk("ld fetch data", {16'h0, i0.data}, 0);
    chk("ld fetch dv", {31'h0, i0.data_valid}, 0);
    chk("ld fetch hold", {31'h0, i0.cpu_hold}, 1);
    for (int k = 0; k < 20; k++) send0(prog[k]);
    pulse0(1'b0, 1'b1);
    chk("prog done", {31'h0, i0.load_done}, 1);
    chk("prog hold", {31'h0, i0.cpu_hold}, 0);
    chk("prog wc", {23'h0, i0.word_count}, 10);
    chk("prog cs", {24'h0, i0.checksum}, {24'h0, cs(8'hE6)});
    @(negedge clk);
    chk("prog done pulse", {31'h0, i0.load_done}, 0);
    chk("prog wc held", {23'h0, i0.word_count}, 10);

    i0.fetch_en = 1'b1;
    i0.address = 8'h05; q0.push_back(16'h6848); @(negedge clk);
    i0.address = 8'h00; q0.push_back(16'h4800); @(negedge clk);
    i0.address = 8'h07; q0.push_back(16'h5C02); @(negedge clk);
    i0.address = 8'h08; q0.push_back(16'h8820); @(negedge clk);
    i0.address = 8'h09; q0.push_back(16'h0000); @(negedge clk);
    i0.address = 8'h02; q0.push_back(16'h4C06); @(negedge clk);
    i0.fetch_en = 1'b0;
    @(negedge clk);
    chk("idle dv", {31'h0, i0.data_valid}, 0);
    chk("idle data hold", {16'h0, i0.data}, {16'h0, 16'h4C06});

    // partial word discarded
    pulse0(1'b1, 1'b0);
    send0(8'hAB); send0(8'hCD); send0(8'hEF);
    pulse0(1'b0, 1'b1);
    chk("part wc", {23'h0, i0.word_count}, 1);
    chk("part cs", {24'h0, i0.checksum}, {24'h0, cs(8'h67)});
    fetch0(8'h00, 16'hABCD);
    fetch0(8'h01, 16'h4A0C);

    // async reset mid-load
    pulse0(1'b1, 1'b0);
    send0(8'h11); send0(8'h22); send0(8'h33);
    send0(8'h44); send0(8'h55);
    #2 rst_n = 1'b0;
    #1;
    chk("arst hold", {31'h0, i0.cpu_hold}, 0);
    chk("arst ready", {31'h0, i0.load_ready}, 0);
    chk("arst wc", {23'h0, i0.word_count}, 0);
    chk("arst cs", {24'h0, i0.checksum}, 0);
    chk("arst data", {16'h0, i0.data}, 0);
    chk("arst dv", {31'h0, i0.data_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst done", {31'h0, i0.load_done}, 0);
    fetch0(8'h00, 16'h1122);
    fetch0(8'h01, 16'h3344);
    fetch0(8'h02, 16'h4C06);

    // start and stop together from RUN
    pulse0(1'b1, 1'b1);
    chk("both hold", {31'h0, i0.cpu_hold}, 1);
    chk("both done", {31'h0, i0.load_done}, 0);
    @(negedge clk);
    chk("both done later", {31'h0, i0.load_done}, 0);

    // word-completing byte with load_stop
    send0(8'hDE);
    i0.load_valid = 1'b1;
    i0.load_byte  = 8'hAD;
    i0.load_stop  = 1'b1;
    @(negedge clk);
    i0.load_valid = 1'b0;
    i0.load_stop  = 1'b0;
    chk("stopw done", {31'h0, i0.load_done}, 1);
    chk("stopw wc", {23'h0, i0.word_count}, 1);
    chk("stopw cs", {24'h0, i0.checksum}, {24'h0, cs(8'h8B)});
    fetch0(8'h00, 16'hDEAD);
    fetch0(8'h01, 16'h3344);

    // load_valid in RUN ignored
    send0(8'hFF); send0(8'hFF);
    chk("run ready", {31'h0, i0.load_ready}, 0);
    chk("run wc", {23'h0, i0.word_count}, 1);
    chk("run cs", {24'h0, i0.checksum}, {24'h0, cs(8'h8B)});
    fetch0(8'h00, 16'hDEAD);

    repeat (2) @(negedge clk);
    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nmis);
    $finish;
  end

endmodule
